// File: rtl/pc_unit_pkg.sv
// Shared constants and types for the program-counter stage of the 5-stage MIPS pipeline.
package pc_unit_pkg;

    localparam logic        RST_ASSERTED = 1'b0;
    localparam logic        CHIP_ENA     = 1'b1;
    localparam logic        CHIP_DISA    = 1'b0;
    localparam logic        STOP         = 1'b1;
    localparam logic        NO_STOP      = 1'b0;

    localparam int          INST_ADDR_W          = 32;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] EXC_ENTRY_ADDR       = 32'hBFC0_0380;

    // Source of the next fetch address, in decreasing priority order.
    typedef enum logic [2:0] {
        SEL_RESET,
        SEL_FLUSH,
        SEL_BRANCH,
        SEL_PENDING,
        SEL_HOLD,
        SEL_INC
    } pc_sel_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// Holds a branch target that arrived while fetch was stalled until the stall releases.
module pc_redirect_buf
    import pc_unit_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_i,
    input  logic              consume_i,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] target_i,
    output logic [ADDR_W-1:0] target_o,
    output logic              valid_o
);

    logic [ADDR_W-1:0] target_d, target_q;
    logic              valid_d, valid_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        target_d = target_q;
        valid_d  = valid_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (set_i) begin
            target_d = target_i;
            valid_d  = 1'b1;
        end else if (consume_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ASSERTED) begin
            target_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            target_q <= target_d;
            valid_q  <= valid_d;
        end
    end

    assign target_o = target_q;
    assign valid_o  = valid_q;

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: fetch address and I-mem enable, with flush, branch and
// stall-buffered redirects.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int                  ADDR_W       = INST_ADDR_W,
    parameter logic [ADDR_W-1:0]   RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR),
    parameter int unsigned         PC_INC       = 4,
    parameter int                  STALL_W      = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  new_pc,
    input  logic               branch_flag,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  pc,
    output logic               ce,
    output logic               redirect_pending
);

    logic [ADDR_W-1:0] pc_d, pc_q;
    logic              ce_d, ce_q;
    logic              stalled;
    logic              buf_set, buf_consume, buf_clear;
    logic [ADDR_W-1:0] pend_target;
    logic              pend_valid;
    pc_sel_e           sel;

    // Only bit 0 of the stall vector belongs to this stage.
    logic unused_stall_hi;
    assign unused_stall_hi = ^stall[STALL_W-1:1];
    assign stalled         = (stall[0] == STOP);

    always_comb begin
        sel = SEL_HOLD;
        if (ce_q == CHIP_DISA)                sel = SEL_RESET;
        else if (flush)                       sel = SEL_FLUSH;
        else if (branch_flag && !stalled)     sel = SEL_BRANCH;
        else if (branch_flag)                 sel = SEL_HOLD;
        else if (pend_valid && !stalled)      sel = SEL_PENDING;
        else if (stalled)                     sel = SEL_HOLD;
        else                                  sel = SEL_INC;
    end

    // A fresh branch or a flush discards any older buffered target.
    assign buf_clear   = (ce_q == CHIP_ENA) && (flush || (branch_flag && !stalled));
    assign buf_set     = (ce_q == CHIP_ENA) && !flush && branch_flag && stalled;
    assign buf_consume = (sel == SEL_PENDING);

    always_comb begin
        ce_d = CHIP_ENA;
        pc_d = pc_q;
        unique case (sel)
            SEL_RESET:   pc_d = RESET_VECTOR;
            SEL_FLUSH:   pc_d = new_pc;
            SEL_BRANCH:  pc_d = branch_target;
            SEL_PENDING: pc_d = pend_target;
            SEL_INC:     pc_d = pc_q + ADDR_W'(PC_INC);
            default:     pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ASSERTED) begin
            pc_q <= RESET_VECTOR;
            ce_q <= CHIP_DISA;
        end else begin
            pc_q <= pc_d;
            ce_q <= ce_d;
        end
    end

    pc_redirect_buf #(.ADDR_W(ADDR_W)) u_redirect_buf (
        .clk       (clk),
        .rst       (rst),
        .set_i     (buf_set),
        .consume_i (buf_consume),
        .clear_i   (buf_clear),
        .target_i  (branch_target),
        .target_o  (pend_target),
        .valid_o   (pend_valid)
    );

    assign pc               = pc_q;
    assign ce               = ce_q;
    assign redirect_pending = pend_valid;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: the driver queues hand-computed expectations, the monitor checks them.
module tb_pc_unit;
    import pc_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic        ce;
    logic        redirect_pending;

    typedef struct {
        logic [31:0] pc;
        logic        ce;
        logic        pend;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    event sample_ev;

    pc_unit dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .flush            (flush),
        .new_pc           (new_pc),
        .branch_flag      (branch_flag),
        .branch_target    (branch_target),
        .pc               (pc),
        .ce               (ce),
        .redirect_pending (redirect_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic push(input logic [31:0] e_pc, input logic e_ce, input logic e_pend, input string name);
        exp_t e;
        e.pc   = e_pc;
        e.ce   = e_ce;
        e.pend = e_pend;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs at the falling edge and queue the state expected after the next rising edge.
    task automatic step(input logic r, input logic [5:0] st, input logic fl, input logic [31:0] npc,
                        input logic br, input logic [31:0] tgt,
                        input logic [31:0] e_pc, input logic e_ce, input logic e_pend, input string name);
        @(negedge clk);
        rst           = r;
        stall         = st;
        flush         = fl;
        new_pc        = npc;
        branch_flag   = br;
        branch_target = tgt;
        push(e_pc, e_ce, e_pend, name);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk or sample_ev);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, ".pc"},   pc,                       e.pc);
                check({e.name, ".ce"},   {31'b0, ce},              {31'b0, e.ce});
                check({e.name, ".pend"}, {31'b0, redirect_pending}, {31'b0, e.pend});
            end
        end
    end

    initial begin : driver
        rst = 1'b0; stall = '0; flush = 1'b0; new_pc = '0; branch_flag = 1'b0; branch_target = '0;

        // Reset held, then release and sequential fetch.
        for (int i = 0; i < 3; i++) step(0, 6'b0, 0, 0, 0, 0, 32'h0, 0, 0, "reset");
        step(1, 6'b0, 0, 0, 0, 0, 32'h00, 1, 0, "release");
        step(1, 6'b0, 0, 0, 0, 0, 32'h04, 1, 0, "inc1");
        step(1, 6'b0, 0, 0, 0, 0, 32'h08, 1, 0, "inc2");
        step(1, 6'b0, 0, 0, 0, 0, 32'h0C, 1, 0, "inc3");
        step(1, 6'b0, 0, 0, 0, 0, 32'h10, 1, 0, "inc4");

        // Stall hold at 0x10.
        for (int i = 0; i < 3; i++) step(1, 6'b000011, 0, 0, 0, 0, 32'h10, 1, 0, "stall_hold");
        step(1, 6'b0, 0, 0, 0, 0, 32'h14, 1, 0, "stall_release");
        step(1, 6'b0, 0, 0, 0, 0, 32'h18, 1, 0, "inc5");
        step(1, 6'b0, 0, 0, 0, 0, 32'h1C, 1, 0, "inc6");
        step(1, 6'b0, 0, 0, 0, 0, 32'h20, 1, 0, "inc7");

        // Unstalled branch.
        step(1, 6'b0, 0, 0, 1, 32'h400, 32'h400, 1, 0, "branch");
        step(1, 6'b0, 0, 0, 0, 0,       32'h404, 1, 0, "branch_inc");

        // Branch during stall is buffered and applied after release.
        step(1, 6'b000001, 0, 0, 1, 32'h800, 32'h404, 1, 1, "br_stall_set");
        step(1, 6'b000001, 0, 0, 0, 0,       32'h404, 1, 1, "br_stall_hold1");
        step(1, 6'b000001, 0, 0, 0, 0,       32'h404, 1, 1, "br_stall_hold2");
        step(1, 6'b0,      0, 0, 0, 0,       32'h800, 1, 0, "br_stall_apply");
        step(1, 6'b0,      0, 0, 0, 0,       32'h804, 1, 0, "br_stall_inc");

        // Latest buffered branch wins.
        step(1, 6'b000001, 0, 0, 1, 32'hA00, 32'h804, 1, 1, "latest_a");
        step(1, 6'b000001, 0, 0, 1, 32'hB00, 32'h804, 1, 1, "latest_b");
        step(1, 6'b0,      0, 0, 0, 0,       32'hB00, 1, 0, "latest_apply");

        // A fresh unstalled branch overrides an older buffered one.
        step(1, 6'b000001, 0, 0, 1, 32'hC00, 32'hB00, 1, 1, "override_buf");
        step(1, 6'b0,      0, 0, 1, 32'hD00, 32'hD00, 1, 0, "override_new");
        step(1, 6'b0,      0, 0, 0, 0,       32'hD04, 1, 0, "override_inc");

        // Flush beats a simultaneous branch and stall, and discards the buffer.
        step(1, 6'b000001, 0, 0, 1, 32'h900, 32'hD04, 1, 1, "flush_pre");
        step(1, 6'b000001, 1, EXC_ENTRY_ADDR, 1, 32'h900, EXC_ENTRY_ADDR, 1, 0, "flush");
        step(1, 6'b0,      0, 0, 0, 0, EXC_ENTRY_ADDR + 32'h4, 1, 0, "flush_inc");

        // Upper stall bits have no effect.
        step(1, 6'b111110, 0, 0, 0, 0, EXC_ENTRY_ADDR + 32'h8, 1, 0, "stall_hi_ignored");

        // Wrap-around at the top of the address space.
        step(1, 6'b0, 0, 0, 1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 1, 0, "wrap_branch");
        step(1, 6'b0, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 0, "wrap_top");
        step(1, 6'b0, 0, 0, 0, 0, 32'h0000_0000, 1, 0, "wrap_zero");
        step(1, 6'b0, 0, 0, 0, 0, 32'h0000_0004, 1, 0, "wrap_inc");

        // Asynchronous reset between edges, with a buffered target present.
        step(1, 6'b000001, 0, 0, 1, 32'h700, 32'h0000_0004, 1, 1, "async_pre");
        @(posedge clk);
        #3;
        rst = 1'b0;
        push(32'h0, 0, 0, "async_reset");
        -> sample_ev;

        // Restart sequence.
        step(0, 6'b0, 0, 0, 0, 0, 32'h0, 0, 0, "restart_hold");
        step(1, 6'b0, 0, 0, 0, 0, 32'h0, 1, 0, "restart_release");
        step(1, 6'b0, 0, 0, 0, 0, 32'h4, 1, 0, "restart_inc");

        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        #2;
        check("scoreboard_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter stage at the head of the 5-stage MIPS pipeline, successor to the simple +4 PC register.
- Supplies the fetch address and instruction-memory chip enable to the IF stage.
- Adds a configurable reset vector, increment and stall width; branch/jump redirect from ID; exception/flush redirect from the ctrl block.
- Buffers a redirect that arrives while fetch is stalled and applies it when the stall releases.

Parameters:
- ADDR_W, 32, width of pc and all target addresses
- RESET_VECTOR, 32'h00000000, pc value while reset or chip disabled
- PC_INC, 4, increment per unstalled cycle
- STALL_W, 6, width of the ctrl stall vector; only bit 0 controls this block

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- stall  in  STALL_W  pipeline stall vector from ctrl; stall[0]=1 holds pc
- flush  in  1  exception/eret flush from ctrl; highest priority
- new_pc  in  ADDR_W  flush target (exception handler or EPC)
- branch_flag  in  1  taken branch/jump from ID, single-cycle pulse
- branch_target  in  ADDR_W  branch/jump destination
- pc  out  ADDR_W  fetch address
- ce  out  1  instruction-memory enable
- redirect_pending  out  1  buffered branch waiting for stall release

Behaviour:
- Reset (rst=0, asynchronous): ce=0, pc=RESET_VECTOR, pending buffer cleared, redirect_pending=0. Outputs hold while rst=0 regardless of clk.
- Chip enable: on the first rising edge after rst deasserts, ce<=1. On that edge pc stays RESET_VECTOR, because ce was 0. The first fetch is therefore RESET_VECTOR with ce=1, one cycle after release.
- While ce=1, pc update priority per rising edge, highest first:
  1. flush=1: pc<=new_pc; pending buffer cleared. Applies even when stall[0]=1.
  2. branch_flag=1 and stall[0]=0: pc<=branch_target; pending buffer cleared, so a new branch overrides an older buffered one.
  3. branch_flag=1 and stall[0]=1: pending target<=branch_target, redirect_pending<=1; pc holds.
  4. redirect_pending=1 and stall[0]=0: pc<=pending target; redirect_pending<=0.
  5. stall[0]=1: pc holds.
  6. Otherwise: pc<=pc+PC_INC.
- A second branch_flag while already pending and still stalled overwrites the pending target (latest wins).
- Arithmetic: increment is modulo 2^ADDR_W. With ADDR_W=32, pc=32'hFFFFFFFC wraps to 32'h00000000 with no error flag.
- Targets are used unmodified; alignment checking belongs to the exception logic.
- Latency: every redirect is visible on pc the cycle after the causing edge; a pending redirect is visible the cycle after stall[0] falls.
- Reset asserted mid-operation clears pending state immediately; ce returns to 0; the restart sequence repeats.
- stall bits above 0 are ignored.

Decomposition:
- Shared define.v: active-low reset level macros (RstAsserted=1'b0), ChipEna/ChipDisa, Stop/NoStop, InstAddrBus default width, RESET_VECTOR default, exception entry address constant.
- One natural sub-module: pc_redirect_buf. It holds the pending target register and valid flag, with set (branch during stall), consume (stall release) and clear (flush/reset) inputs.
- All remaining logic stays in pc_unit.

Test Plan:
- Reset release: rst low 3 cycles, then high, no stall. Expect ce=0 and pc=0 during reset; ce=1 at edge 1 with pc=0; pc=4, 8, 12 on the following edges.
- Stall hold: stall=6'b000011 for 3 cycles at pc=0x10. Expect pc stays 0x10 for all 3 cycles, then 0x14 after release.
- Branch unstalled: branch_flag pulse with target 0x400 at pc=0x20. Expect pc=0x400 next cycle, then 0x404.
- Branch during stall: stall[0]=1, branch to 0x800, hold stall 2 more cycles. Expect redirect_pending=1 and pc unchanged during stall; pc=0x800 the cycle after release; redirect_pending=0.
- Flush priority: same edge as branch_flag (target 0x900) and stall[0]=1, with flush=1 and new_pc=0xBFC00380. Expect pc=0xBFC00380 and redirect_pending=0.
- Wrap and async reset: run pc to 0xFFFFFFFC and expect 0x00000000 next. Then drop rst between clock edges; expect pc=RESET_VECTOR and ce=0 immediately, without waiting for a clock edge.
